// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 control unit.
// A Moore FSM walks each instruction through fetch/decode/execute/memory/writeback
// and drives the shared-datapath control lines. Memory states stall on mem_ready.
module multicycle_control #(
  parameter int unsigned   OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = OPW'(0),
  parameter logic [OPW-1:0] OP_LW    = OPW'(35),
  parameter logic [OPW-1:0] OP_SW    = OPW'(43),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(4),
  parameter logic [OPW-1:0] OP_BNE   = OPW'(5),
  parameter logic [OPW-1:0] OP_ADDI  = OPW'(8),
  parameter logic [OPW-1:0] OP_J     = OPW'(2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           branch_ne,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StTrap   = 4'd12
  } state_e;

  state_e state_q, state_d;

  assign state = state_q;

  // Next-state logic; unused codes 13-15 fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (opcode == OP_LW || opcode == OP_SW)        state_d = StMemAdr;
        else if (opcode == OP_RTYPE)                   state_d = StExec;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = StBranch;
        else if (opcode == OP_ADDI)                    state_d = StAddiEx;
        else if (opcode == OP_J)                       state_d = StJump;
        else                                           state_d = StTrap;
      end
      StMemAdr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StTrap:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // State register with asynchronous reset into FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; write strobes are suppressed while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StTrap:  illegal_op = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table walks every instruction
// class (with stalls), plus hand-written reset sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int tests  = 0;
  int errors = 0;

  multicycle_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne    (branch_ne),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .illegal_op   (illegal_op),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Control word layout:
  // pc_write pc_write_cond branch_ne iord mem_read mem_write ir_write mem_to_reg reg_dst
  // reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0] illegal_op
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                illegal_op};

  localparam logic [17:0] C_FETCH1 = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_FETCH0 = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] C_MEMADR = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_MEMRD  = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_MEMWB  = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] C_MEMWR  = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_EXEC   = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] C_BEQ    = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_BNE    = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_ADDIEX = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_ADDIWB = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [17:0] C_TRAP   = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [17:0] c);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.c = c;
    vecs.push_back(v);
  endtask

  initial begin
    // lw, no stall: 0,1,2,3,4
    add(35, 1, 0, C_FETCH1); add(35, 1, 1, C_DECODE); add(35, 1, 2, C_MEMADR);
    add(35, 1, 3, C_MEMRD);  add(35, 1, 4, C_MEMWB);
    // sw with two stall cycles in MEMWR (6 cycles total)
    add(43, 1, 0, C_FETCH1); add(43, 1, 1, C_DECODE); add(43, 1, 2, C_MEMADR);
    add(43, 0, 5, C_MEMWR);  add(43, 0, 5, C_MEMWR);  add(43, 1, 5, C_MEMWR);
    // beq with one FETCH stall, then bne
    add(4, 0, 0, C_FETCH0);  add(4, 1, 0, C_FETCH1);  add(4, 1, 1, C_DECODE);
    add(4, 1, 8, C_BEQ);
    add(5, 1, 0, C_FETCH1);  add(5, 1, 1, C_DECODE);  add(5, 1, 8, C_BNE);
    // R-type; mem_ready low in DECODE/EXEC must be ignored
    add(0, 1, 0, C_FETCH1);  add(0, 0, 1, C_DECODE);  add(0, 0, 6, C_EXEC);
    add(0, 1, 7, C_ALUWB);
    // addi
    add(8, 1, 0, C_FETCH1);  add(8, 1, 1, C_DECODE);  add(8, 1, 10, C_ADDIEX);
    add(8, 1, 11, C_ADDIWB);
    // j
    add(2, 1, 0, C_FETCH1);  add(2, 1, 1, C_DECODE);  add(2, 1, 9, C_JUMP);
    // illegal opcode: single-cycle TRAP
    add(63, 1, 0, C_FETCH1); add(63, 1, 1, C_DECODE); add(63, 1, 12, C_TRAP);
    // lw with one stall in MEMRD
    add(35, 1, 0, C_FETCH1); add(35, 1, 1, C_DECODE); add(35, 1, 2, C_MEMADR);
    add(35, 0, 3, C_MEMRD);  add(35, 1, 3, C_MEMRD);  add(35, 1, 4, C_MEMWB);
    add(0, 1, 0, C_FETCH1);

    // Power-on reset: write strobes gated even though mem_ready=1
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(ctl), 32'(C_FETCH0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      #2;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].c));
    end

    // Reset mid-instruction: last vector left FETCH with R-type, mem_ready=1
    @(negedge clk); #2;
    check("midrst_decode", 32'(state), 32'd1);
    @(negedge clk); #2;
    check("midrst_exec", 32'(state), 32'd6);
    #1 rst = 1'b1;
    #1;
    check("midrst_state_now", 32'(state), 32'd0);
    check("midrst_ctl_now", 32'(ctl), 32'(C_FETCH0));
    @(posedge clk); #1;
    check("midrst_state_held", 32'(state), 32'd0);
    check("midrst_reg_write", 32'(reg_write), 32'd0);
    check("midrst_ctl_held", 32'(ctl), 32'(C_FETCH0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_release_state", 32'(state), 32'd0);
    check("midrst_release_mem_read", 32'(mem_read), 32'd1);
    check("midrst_release_ctl", 32'(ctl), 32'(C_FETCH1));
    @(negedge clk); #2;
    check("midrst_restart_decode", 32'(state), 32'd1);

    // Reset during a MEMWR stall: mem_write must drop as soon as rst rises
    opcode = 6'd43;
    @(negedge clk); #2;
    check("swrst_memadr", 32'(state), 32'd2);
    mem_ready = 1'b0;
    @(negedge clk); #2;
    check("swrst_memwr", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("swrst_mem_write", 32'(mem_write), 32'd0);
    check("swrst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
